sc_boundarydetector_multimode: RTL and testbench

//  Parametrised, registered successor of the single-pattern side comparator for the LED-matrix game datapath.

---
 rtl/sc_boundarydetector_pkg.sv | 15 +
 rtl/sc_boundarydetector_match.sv | 23 ++
 rtl/sc_boundarydetector_multimode.sv | 127 ++++++++++++
 tb/tb_sc_boundarydetector_multimode.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_boundarydetector_pkg.sv
// Shared mode constants and FSM state encoding for the boundary detector.
package sc_boundarydetector_pkg;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_ANY   = 2'b01;
  localparam logic [1:0] MODE_ALL   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_QUAL = 2'b01,
    S_HIT  = 2'b10
  } state_t;

endpackage

// File: rtl/sc_boundarydetector_match.sv
// Combinational data-vs-mask comparator for the three match modes.
module sc_boundarydetector_match
  import sc_boundarydetector_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] data,
  input  logic [DATAWIDTH-1:0] mask,
  input  logic [1:0]           mode,
  output logic                 match
);

  always_comb begin
    match = 1'b0;
    case (mode)
      MODE_EXACT: match = (data == mask);
      MODE_ANY:   match = ((data & mask) != '0);
      MODE_ALL:   match = ((data & mask) == mask);
      default:    match = 1'b0;
    endcase
  end

endmodule

// File: rtl/sc_boundarydetector_multimode.sv
// Registered multi-mode boundary detector with hold qualification and hit pulse.
// Optional hit counter port enabled by `define BOUNDARYDETECTOR_HITCOUNT_EN.
module sc_boundarydetector_multimode
  import sc_boundarydetector_pkg::*;
#(
  parameter int                   DATAWIDTH = 8,
  parameter int                   HOLD      = 1,
  parameter int                   STICKY    = 0,
  parameter logic [DATAWIDTH-1:0] MASK_RST  = 8'b00010000
) (
  input  logic                 SC_BOUNDARYDETECTOR_CLOCK_50,
  input  logic                 SC_BOUNDARYDETECTOR_RESET_InLow,
  input  logic [DATAWIDTH-1:0] SC_BOUNDARYDETECTOR_data_InBUS,
  input  logic                 SC_BOUNDARYDETECTOR_valid_InHigh,
  input  logic [1:0]           SC_BOUNDARYDETECTOR_mode_InBUS,
  input  logic [DATAWIDTH-1:0] SC_BOUNDARYDETECTOR_mask_InBUS,
  input  logic                 SC_BOUNDARYDETECTOR_maskload_InHigh,
  input  logic                 SC_BOUNDARYDETECTOR_clear_InHigh,
  output logic                 SC_BOUNDARYDETECTOR_match_OutHigh,
  output logic                 SC_BOUNDARYDETECTOR_hit_OutHigh,
  output logic                 SC_BOUNDARYDETECTOR_hitpulse_OutHigh
`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
  ,
  output logic [7:0]           SC_BOUNDARYDETECTOR_hitcount_OutBUS
`endif
);

  localparam int QW = $clog2(HOLD + 1);
  localparam logic [QW-1:0] HOLD_Q = QW'(HOLD);

  state_t               state, state_nxt;
  logic [QW-1:0]        qualcnt, qualcnt_nxt;
  logic [DATAWIDTH-1:0] mask;
  logic                 raw_match;
  logic                 hit_q, pulse_q;

  sc_boundarydetector_match #(.DATAWIDTH(DATAWIDTH)) u_match (
    .data  (SC_BOUNDARYDETECTOR_data_InBUS),
    .mask  (mask),
    .mode  (SC_BOUNDARYDETECTOR_mode_InBUS),
    .match (raw_match)
  );

  assign SC_BOUNDARYDETECTOR_match_OutHigh    = SC_BOUNDARYDETECTOR_valid_InHigh & raw_match;
  assign SC_BOUNDARYDETECTOR_hit_OutHigh      = hit_q;
  assign SC_BOUNDARYDETECTOR_hitpulse_OutHigh = pulse_q;

  always_comb begin
    state_nxt   = state;
    qualcnt_nxt = qualcnt;
    if (SC_BOUNDARYDETECTOR_clear_InHigh) begin
      state_nxt   = S_IDLE;
      qualcnt_nxt = '0;
    end else if (SC_BOUNDARYDETECTOR_valid_InHigh) begin
      case (state)
        S_IDLE: begin
          if (raw_match) begin
            if (HOLD == 1) begin
              state_nxt   = S_HIT;
              qualcnt_nxt = HOLD_Q;
            end else begin
              state_nxt   = S_QUAL;
              qualcnt_nxt = QW'(1);
            end
          end
        end
        S_QUAL: begin
          if (raw_match) begin
            if (qualcnt + QW'(1) == HOLD_Q) begin
              state_nxt   = S_HIT;
              qualcnt_nxt = HOLD_Q;
            end else begin
              qualcnt_nxt = qualcnt + QW'(1);
            end
          end else begin
            state_nxt   = S_IDLE;
            qualcnt_nxt = '0;
          end
        end
        S_HIT: begin
          if (!raw_match && STICKY == 0) begin
            state_nxt   = S_IDLE;
            qualcnt_nxt = '0;
          end
        end
        default: begin
          state_nxt   = S_IDLE;
          qualcnt_nxt = '0;
        end
      endcase
    end
  end

  // hit and pulse derive from the next state so they rise on the qualifying edge.
  always_ff @(posedge SC_BOUNDARYDETECTOR_CLOCK_50 or negedge SC_BOUNDARYDETECTOR_RESET_InLow) begin
    if (!SC_BOUNDARYDETECTOR_RESET_InLow) begin
      state   <= S_IDLE;
      qualcnt <= '0;
      mask    <= MASK_RST;
      hit_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      qualcnt <= qualcnt_nxt;
      hit_q   <= (state_nxt == S_HIT);
      pulse_q <= (state_nxt == S_HIT) && (state != S_HIT);
      if (SC_BOUNDARYDETECTOR_maskload_InHigh)
        mask <= SC_BOUNDARYDETECTOR_mask_InBUS;
    end
  end

`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
  logic [7:0] hitcount;

  always_ff @(posedge SC_BOUNDARYDETECTOR_CLOCK_50 or negedge SC_BOUNDARYDETECTOR_RESET_InLow) begin
    if (!SC_BOUNDARYDETECTOR_RESET_InLow)
      hitcount <= 8'h00;
    else if (SC_BOUNDARYDETECTOR_clear_InHigh)
      hitcount <= 8'h00;
    else if (pulse_q && hitcount != 8'hFF)
      hitcount <= hitcount + 8'h01;
  end

  assign SC_BOUNDARYDETECTOR_hitcount_OutBUS = hitcount;
`endif

endmodule

// File: tb/tb_sc_boundarydetector_multimode.sv
// Directed self-checking bench: four detector instances (default, HOLD=3, STICKY=1, HOLD=4) share stimulus.
module tb_sc_boundarydetector_multimode;

  localparam logic [1:0] M_EXACT = 2'b00;
  localparam logic [1:0] M_ANY   = 2'b01;
  localparam logic [1:0] M_ALL   = 2'b10;
  localparam logic [1:0] M_RSVD  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data, mask_in;
  logic       valid, maskload, clear;
  logic [1:0] mode;

  logic m_d, h_d, p_d;
  logic m_3, h_3, p_3;
  logic m_s, h_s, p_s;
  logic m_4, h_4, p_4;
`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
  logic [7:0] hc_d, hc_3, hc_s, hc_4;
`endif

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  sc_boundarydetector_multimode u_def (
    .SC_BOUNDARYDETECTOR_CLOCK_50        (clk),
    .SC_BOUNDARYDETECTOR_RESET_InLow     (rst_n),
    .SC_BOUNDARYDETECTOR_data_InBUS      (data),
    .SC_BOUNDARYDETECTOR_valid_InHigh    (valid),
    .SC_BOUNDARYDETECTOR_mode_InBUS      (mode),
    .SC_BOUNDARYDETECTOR_mask_InBUS      (mask_in),
    .SC_BOUNDARYDETECTOR_maskload_InHigh (maskload),
    .SC_BOUNDARYDETECTOR_clear_InHigh    (clear),
    .SC_BOUNDARYDETECTOR_match_OutHigh   (m_d),
    .SC_BOUNDARYDETECTOR_hit_OutHigh     (h_d),
    .SC_BOUNDARYDETECTOR_hitpulse_OutHigh(p_d)
`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
    , .SC_BOUNDARYDETECTOR_hitcount_OutBUS(hc_d)
`endif
  );

  sc_boundarydetector_multimode #(.HOLD(3)) u_h3 (
    .SC_BOUNDARYDETECTOR_CLOCK_50        (clk),
    .SC_BOUNDARYDETECTOR_RESET_InLow     (rst_n),
    .SC_BOUNDARYDETECTOR_data_InBUS      (data),
    .SC_BOUNDARYDETECTOR_valid_InHigh    (valid),
    .SC_BOUNDARYDETECTOR_mode_InBUS      (mode),
    .SC_BOUNDARYDETECTOR_mask_InBUS      (mask_in),
    .SC_BOUNDARYDETECTOR_maskload_InHigh (maskload),
    .SC_BOUNDARYDETECTOR_clear_InHigh    (clear),
    .SC_BOUNDARYDETECTOR_match_OutHigh   (m_3),
    .SC_BOUNDARYDETECTOR_hit_OutHigh     (h_3),
    .SC_BOUNDARYDETECTOR_hitpulse_OutHigh(p_3)
`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
    , .SC_BOUNDARYDETECTOR_hitcount_OutBUS(hc_3)
`endif
  );

  sc_boundarydetector_multimode #(.STICKY(1)) u_st (
    .SC_BOUNDARYDETECTOR_CLOCK_50        (clk),
    .SC_BOUNDARYDETECTOR_RESET_InLow     (rst_n),
    .SC_BOUNDARYDETECTOR_data_InBUS      (data),
    .SC_BOUNDARYDETECTOR_valid_InHigh    (valid),
    .SC_BOUNDARYDETECTOR_mode_InBUS      (mode),
    .SC_BOUNDARYDETECTOR_mask_InBUS      (mask_in),
    .SC_BOUNDARYDETECTOR_maskload_InHigh (maskload),
    .SC_BOUNDARYDETECTOR_clear_InHigh    (clear),
    .SC_BOUNDARYDETECTOR_match_OutHigh   (m_s),
    .SC_BOUNDARYDETECTOR_hit_OutHigh     (h_s),
    .SC_BOUNDARYDETECTOR_hitpulse_OutHigh(p_s)
`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
    , .SC_BOUNDARYDETECTOR_hitcount_OutBUS(hc_s)
`endif
  );

  sc_boundarydetector_multimode #(.HOLD(4)) u_h4 (
    .SC_BOUNDARYDETECTOR_CLOCK_50        (clk),
    .SC_BOUNDARYDETECTOR_RESET_InLow     (rst_n),
    .SC_BOUNDARYDETECTOR_data_InBUS      (data),
    .SC_BOUNDARYDETECTOR_valid_InHigh    (valid),
    .SC_BOUNDARYDETECTOR_mode_InBUS      (mode),
    .SC_BOUNDARYDETECTOR_mask_InBUS      (mask_in),
    .SC_BOUNDARYDETECTOR_maskload_InHigh (maskload),
    .SC_BOUNDARYDETECTOR_clear_InHigh    (clear),
    .SC_BOUNDARYDETECTOR_match_OutHigh   (m_4),
    .SC_BOUNDARYDETECTOR_hit_OutHigh     (h_4),
    .SC_BOUNDARYDETECTOR_hitpulse_OutHigh(p_4)
`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
    , .SC_BOUNDARYDETECTOR_hitcount_OutBUS(hc_4)
`endif
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; combinational match is checked 1ns later.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] md,
                               input logic ld, input logic [7:0] mk, input logic clr);
    @(negedge clk);
    valid    = v;
    data     = d;
    mode     = md;
    maskload = ld;
    mask_in  = mk;
    clear    = clr;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t2Data[6]     = '{8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h10};
  logic       t2Hit3[6]     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       t2DefPulse[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       t6Hit4[4]     = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; mode = M_EXACT;
    maskload = 1'b0; mask_in = 8'h00; clear = 1'b0;
    #12;
    checkOutput("rst_hit", h_d, 8'h0);
    checkOutput("rst_pulse", p_d, 8'h0);
    checkOutput("rst_match", m_d, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic EXACT hit with HOLD=1, then drop on mismatch.
    applyStimulus(1'b1, 8'h10, M_EXACT, 1'b0, 8'h00, 1'b0);
    checkOutput("t1_match", m_d, 8'h1);
    clockEdge();
    checkOutput("t1_hit", h_d, 8'h1);
    checkOutput("t1_pulse", p_d, 8'h1);
    checkOutput("t1_h3_nohit", h_3, 8'h0);
    applyStimulus(1'b1, 8'h11, M_EXACT, 1'b0, 8'h00, 1'b0);
    checkOutput("t1_nomatch", m_d, 8'h0);
    clockEdge();
    checkOutput("t1_drop", h_d, 8'h0);
    checkOutput("t1_pulse_gone", p_d, 8'h0);
    checkOutput("t4_sticky_hold", h_s, 8'h1);

    // Clear beats a valid matching sample.
    applyStimulus(1'b1, 8'h10, M_EXACT, 1'b0, 8'h00, 1'b1);
    checkOutput("t4_match_during_clear", m_s, 8'h1);
    clockEdge();
    checkOutput("t4_clear_hit", h_s, 8'h0);
    checkOutput("t4_clear_pulse", p_s, 8'h0);
    checkOutput("t4_clear_def", h_d, 8'h0);

    // HOLD=3 qualification with an interrupting mismatch.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, t2Data[i], M_EXACT, 1'b0, 8'h00, 1'b0);
      clockEdge();
      checkOutput($sformatf("t2_h3_hit%0d", i), h_3, 8'(t2Hit3[i]));
      checkOutput($sformatf("t2_h3_pulse%0d", i), p_3, 8'(t2Hit3[i]));
      checkOutput($sformatf("t2_def_pulse%0d", i), p_d, 8'(t2DefPulse[i]));
    end
    applyStimulus(1'b1, 8'h10, M_EXACT, 1'b0, 8'h00, 1'b0);
    clockEdge();
    checkOutput("t2_h3_stay", h_3, 8'h1);
    checkOutput("t2_h3_single_pulse", p_3, 8'h0);
    checkOutput("t2_h4_hit", h_4, 8'h1);
    checkOutput("t2_h4_pulse", p_4, 8'h1);
    applyStimulus(1'b0, 8'h00, M_EXACT, 1'b0, 8'h00, 1'b0);
    clockEdge();
    checkOutput("t2_idle_hold", h_3, 8'h1);
    checkOutput("t2_idle_nopulse", p_4, 8'h0);

    // Clear and maskload together, then ANY / ALL / reserved modes with mask 81.
    applyStimulus(1'b0, 8'h00, M_EXACT, 1'b1, 8'h81, 1'b1);
    clockEdge();
    checkOutput("t3_clear_h3", h_3, 8'h0);
    checkOutput("t3_clear_h4", h_4, 8'h0);
    applyStimulus(1'b1, 8'h01, M_ANY, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_any_match", m_d, 8'h1);
    clockEdge();
    checkOutput("t3_any_hit", h_d, 8'h1);
    checkOutput("t3_any_pulse", p_d, 8'h1);
    applyStimulus(1'b1, 8'h01, M_ALL, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_all_nomatch", m_d, 8'h0);
    clockEdge();
    checkOutput("t3_all_nohit", h_d, 8'h0);
    applyStimulus(1'b1, 8'hFF, M_ALL, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_all_match", m_d, 8'h1);
    clockEdge();
    checkOutput("t3_all_hit", h_d, 8'h1);
    checkOutput("t3_all_pulse", p_d, 8'h1);
    applyStimulus(1'b1, 8'h81, M_ALL, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_all_exact_mask", m_d, 8'h1);
    clockEdge();
    applyStimulus(1'b1, 8'hFF, M_RSVD, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_rsvd_ff", m_d, 8'h0);
    checkOutput("t3_rsvd_ff_h3", m_3, 8'h0);
    clockEdge();
    checkOutput("t3_rsvd_drop", h_d, 8'h0);
    applyStimulus(1'b1, 8'h81, M_RSVD, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_rsvd_81", m_4, 8'h0);
    clockEdge();
    applyStimulus(1'b1, 8'h81, M_EXACT, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_exact_81", m_s, 8'h1);
    clockEdge();

    // Mask load takes effect only for the following compare.
    applyStimulus(1'b0, 8'h00, M_EXACT, 1'b1, 8'h10, 1'b0);
    clockEdge();
    applyStimulus(1'b1, 8'h08, M_EXACT, 1'b1, 8'h08, 1'b0);
    checkOutput("t5_old_mask", m_d, 8'h0);
    clockEdge();
    checkOutput("t5_old_mask_hit", h_d, 8'h0);
    applyStimulus(1'b1, 8'h08, M_EXACT, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_new_mask", m_d, 8'h1);
    clockEdge();
    checkOutput("t5_new_mask_hit", h_d, 8'h1);
    checkOutput("t5_new_mask_pulse", p_d, 8'h1);

    // Async reset while HOLD=4 instance has seen two matches.
    applyStimulus(1'b0, 8'h00, M_EXACT, 1'b0, 8'h00, 1'b1);
    clockEdge();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'h08, M_EXACT, 1'b0, 8'h00, 1'b0);
      clockEdge();
    end
    checkOutput("t6_h4_qual", h_4, 8'h0);
    checkOutput("t6_def_hit_before_rst", h_d, 8'h1);
    @(negedge clk);
    rst_n = 1'b0;
    data  = 8'h10;
    #1;
    checkOutput("t6_rst_h4", h_4, 8'h0);
    checkOutput("t6_rst_p4", p_4, 8'h0);
    checkOutput("t6_rst_def_hit", h_d, 8'h0);
    checkOutput("t6_rst_def_pulse", p_d, 8'h0);
    checkOutput("t6_rst_mask", m_d, 8'h1);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h10, M_EXACT, 1'b0, 8'h00, 1'b0);
      clockEdge();
      checkOutput($sformatf("t6_h4_hit%0d", i), h_4, 8'(t6Hit4[i]));
      checkOutput($sformatf("t6_h4_pulse%0d", i), p_4, 8'(t6Hit4[i]));
    end

`ifdef BOUNDARYDETECTOR_HITCOUNT_EN
    checkOutput("hc_after_rst", hc_d, 8'h01);
    applyStimulus(1'b0, 8'h00, M_EXACT, 1'b0, 8'h00, 1'b1);
    clockEdge();
    checkOutput("hc_clear", hc_d, 8'h00);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 8'h11, M_EXACT, 1'b0, 8'h00, 1'b0);
      clockEdge();
      applyStimulus(1'b1, 8'h10, M_EXACT, 1'b0, 8'h00, 1'b0);
      clockEdge();
      if (i == 9) checkOutput("hc_ten", hc_d, 8'h09);
    end
    applyStimulus(1'b0, 8'h00, M_EXACT, 1'b0, 8'h00, 1'b0);
    clockEdge();
    checkOutput("hc_saturate", hc_d, 8'hFF);
    checkOutput("hc_h3", hc_3, 8'h00);
    checkOutput("hc_st", hc_s, 8'h01);
    checkOutput("hc_h4", hc_4, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
